// File: rtl/instr_assembler.sv
// Fetch-side instruction assembler: pairs prefix/suffix words into 64-bit
// instructions, flags prefixes at the end of a 64-byte block, and queues results for decode.
module instr_assembler #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_fetch_valid,
  output logic                     o_fetch_ready,
  input  logic [0:31]              i_fetch_word,
  input  logic [0:ADDR_W-1]        i_fetch_addr,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [0:63]              o_instr,
  output logic [0:ADDR_W-1]        o_addr,
  output logic                     o_prefixed,
  output logic                     o_align_err,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [0:31]       hold_word_r;
  logic [0:ADDR_W-1] hold_addr_r;
  logic [0:63]       mem_instr_r [DEPTH];
  logic [0:ADDR_W-1] mem_addr_r  [DEPTH];
  logic              mem_pref_r  [DEPTH];
  logic              mem_err_r   [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic              accept_s, pop_s, push_s, hold_load_s;
  logic              is_prefix_s, at_edge_s;
  logic [0:63]       push_instr_s;
  logic [0:ADDR_W-1] push_addr_s;
  logic              push_pref_s, push_err_s;

  // Ready depends only on registered state and the flush input, never on i_ready.
  assign o_fetch_ready = !i_flush && (state_r != HALT) && (count_r < CW'(DEPTH));
  assign o_valid       = (count_r != {CW{1'b0}});
  assign o_count       = count_r;

  // Next-state and push selection for the pairing FSM.
  always_comb begin
    accept_s     = i_fetch_valid && o_fetch_ready;
    is_prefix_s  = (i_fetch_word[0:5] == 6'b000001);
    at_edge_s    = (i_fetch_addr[ADDR_W-6:ADDR_W-1] == 6'b111100);
    state_s      = state_r;
    push_s       = 1'b0;
    hold_load_s  = 1'b0;
    push_instr_s = {i_fetch_word, 32'h0000_0000};
    push_addr_s  = i_fetch_addr;
    push_pref_s  = 1'b0;
    push_err_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (is_prefix_s && at_edge_s) begin
            // The suffix would fall in the next block: emit the prefix alone, flagged.
            push_s      = 1'b1;
            push_pref_s = 1'b1;
            push_err_s  = 1'b1;
            state_s     = HALT;
          end else if (is_prefix_s) begin
            hold_load_s = 1'b1;
            state_s     = PREFIX;
          end else begin
            push_s = 1'b1;
          end
        end
        PREFIX: begin
          push_s       = 1'b1;
          push_instr_s = {hold_word_r, i_fetch_word};
          push_addr_s  = hold_addr_r;
          push_pref_s  = 1'b1;
          state_s      = IDLE;
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    pop_s = o_valid && i_ready && !i_flush;
  end

  // Head-of-FIFO outputs, forced to zero while empty.
  always_comb begin
    if (o_valid) begin
      o_instr     = mem_instr_r[rd_ptr_r];
      o_addr      = mem_addr_r[rd_ptr_r];
      o_prefixed  = mem_pref_r[rd_ptr_r];
      o_align_err = mem_err_r[rd_ptr_r];
    end else begin
      o_instr     = 64'h0;
      o_addr      = {ADDR_W{1'b0}};
      o_prefixed  = 1'b0;
      o_align_err = 1'b0;
    end
  end

  // FSM, prefix holding register and FIFO pointers; flush overrides everything.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= IDLE;
      hold_word_r <= 32'h0;
      hold_addr_r <= {ADDR_W{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
    end else if (i_flush) begin
      state_r     <= IDLE;
      hold_word_r <= 32'h0;
      hold_addr_r <= {ADDR_W{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      if (hold_load_s) begin
        hold_word_r <= i_fetch_word;
        hold_addr_r <= i_fetch_addr;
      end
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    end
  end

  // FIFO storage.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_r[i] <= 64'h0;
        mem_addr_r[i]  <= {ADDR_W{1'b0}};
        mem_pref_r[i]  <= 1'b0;
        mem_err_r[i]   <= 1'b0;
      end
    end else if (push_s) begin
      mem_instr_r[wr_ptr_r] <= push_instr_s;
      mem_addr_r[wr_ptr_r]  <= push_addr_s;
      mem_pref_r[wr_ptr_r]  <= push_pref_s;
      mem_err_r[wr_ptr_r]   <= push_err_s;
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler; expected entries are queued when driven
// and compared against the FIFO head whenever decode consumes it.
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [0:31] fetch_word = 32'h0;
  logic [0:63] fetch_addr = 64'h0;
  logic        valid;
  logic        ready = 1'b0;
  logic [0:63] instr;
  logic [0:63] addr;
  logic        prefixed;
  logic        align_err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:63] instr;
    logic [0:63] addr;
    logic        pref;
    logic        err;
  } exp_t;
  exp_t q[$];

  instr_assembler #(.DEPTH(4), .ADDR_W(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_fetch_valid(fetch_valid), .o_fetch_ready(fetch_ready),
    .i_fetch_word(fetch_word), .i_fetch_addr(fetch_addr),
    .o_valid(valid), .i_ready(ready), .o_instr(instr), .o_addr(addr),
    .o_prefixed(prefixed), .o_align_err(align_err), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [0:63] i, input logic [0:63] a, input logic p, input logic e);
    exp_t x;
    x.instr = i; x.addr = a; x.pref = p; x.err = e;
    q.push_back(x);
  endtask

  // One clock: compare the head at the falling edge if it is consumed, then step past the rising edge.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    if (valid && ready && !flush) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=%h expected=none", instr);
      end
      if (q.size() > 0) begin
        x = q.pop_front();
        check("head_instr", instr, x.instr);
        check("head_addr", addr, x.addr);
        check("head_pref", {63'h0, prefixed}, {63'h0, x.pref});
        check("head_err", {63'h0, align_err}, {63'h0, x.err});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [0:31] w, input logic [0:63] a);
    fetch_valid = 1'b1;
    fetch_word  = w;
    fetch_addr  = a;
    #1;
    check("send_ready", {63'h0, fetch_ready}, 64'h1);
    tick();
    fetch_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", {63'h0, valid}, 64'h0);
    check("rst_count", {61'h0, count}, 64'h0);
    check("rst_instr", instr, 64'h0);
    check("rst_addr", addr, 64'h0);
    check("rst_flags", {62'h0, prefixed, align_err}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rel_ready", {63'h0, fetch_ready}, 64'h1);

    // Plain stream with one-cycle latency
    ready = 1'b1;
    exp_push(64'h38600005_00000000, 64'h100, 1'b0, 1'b0);
    send(32'h38600005, 64'h100);
    check("plain_lat0", {63'h0, valid}, 64'h1);
    exp_push(64'h48000010_00000000, 64'h104, 1'b0, 1'b0);
    send(32'h48000010, 64'h104);
    check("plain_lat1", {63'h0, valid}, 64'h1);
    tick();
    check("plain_empty", {63'h0, valid}, 64'h0);

    // Prefixed pair
    send(32'h04000000, 64'h200);
    check("prefix_alone", {63'h0, valid}, 64'h0);
    exp_push(64'h04000000_38600005, 64'h200, 1'b1, 1'b0);
    send(32'h38600005, 64'h204);
    check("pair_lat", {63'h0, valid}, 64'h1);
    tick();

    // Prefix at byte offset 60 halts fetch until flush
    exp_push(64'h04000000_00000000, 64'h23C, 1'b1, 1'b1);
    send(32'h04000000, 64'h23C);
    check("halt_valid", {63'h0, valid}, 64'h1);
    tick();
    fetch_valid = 1'b1; fetch_word = 32'h38600005; fetch_addr = 64'h240;
    tick();
    tick();
    check("halt_ready", {63'h0, fetch_ready}, 64'h0);
    check("halt_count", {61'h0, count}, 64'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    #1;
    check("halt_flush_ready", {63'h0, fetch_ready}, 64'h1);
    check("halt_flush_count", {61'h0, count}, 64'h0);

    // Backpressure, full FIFO, pointer wrap over 8 entries
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_push({32'h38600010 + 32'(k), 32'h0}, 64'h300 + 64'(4 * k), 1'b0, 1'b0);
      send(32'h38600010 + 32'(k), 64'h300 + 64'(4 * k));
    end
    check("full_count", {61'h0, count}, 64'h4);
    check("full_ready", {63'h0, fetch_ready}, 64'h0);
    exp_push(64'h38600014_00000000, 64'h310, 1'b0, 1'b0);
    fetch_valid = 1'b1; fetch_word = 32'h38600014; fetch_addr = 64'h310;
    ready = 1'b1;
    tick();
    check("full_pop_only", {61'h0, count}, 64'h3);
    tick();
    fetch_valid = 1'b0;
    check("resume_count", {61'h0, count}, 64'h3);
    for (int k = 5; k < 8; k++) begin
      exp_push({32'h38600010 + 32'(k), 32'h0}, 64'h300 + 64'(4 * k), 1'b0, 1'b0);
      send(32'h38600010 + 32'(k), 64'h300 + 64'(4 * k));
    end
    for (int k = 0; k < 4; k++) tick();
    check("wrap_drained", {61'h0, count}, 64'h0);

    // Flush mid-pair with an entry queued
    ready = 1'b0;
    send(32'h60000000, 64'h3F0);
    send(32'h04000000, 64'h400);
    check("fl_pre_count", {61'h0, count}, 64'h1);
    fetch_valid = 1'b1; fetch_word = 32'h38600005; fetch_addr = 64'h404;
    flush = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    q.delete();
    check("fl_valid", {63'h0, valid}, 64'h0);
    check("fl_count", {61'h0, count}, 64'h0);
    ready = 1'b1;
    exp_push(64'h38600005_00000000, 64'h408, 1'b0, 1'b0);
    send(32'h38600005, 64'h408);
    tick();

    // Async reset with two entries queued and a prefix held
    ready = 1'b0;
    send(32'h38600001, 64'h480);
    send(32'h38600002, 64'h484);
    send(32'h04000000, 64'h488);
    check("ar_pre_count", {61'h0, count}, 64'h2);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", {63'h0, valid}, 64'h0);
    check("ar_count", {61'h0, count}, 64'h0);
    check("ar_instr", instr, 64'h0);
    q.delete();
    tick();
    rst = 1'b1;
    #1;
    check("ar_rel_ready", {63'h0, fetch_ready}, 64'h1);
    ready = 1'b1;
    exp_push(64'h38600005_00000000, 64'h500, 1'b0, 1'b0);
    send(32'h38600005, 64'h500);
    check("ar_idle_plain", {63'h0, valid}, 64'h1);
    tick();
    tick();

    check("sb_empty", 64'(q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Fetch-side stage directly upstream of the instruction identification/decode stage.
- Accepts a stream of 32-bit instruction words with their byte addresses.
- Pairs each Power ISA prefix word (primary opcode 1) with the following suffix word into one 64-bit instruction.
- Flags prefixed instructions that cross a 64-byte boundary, and buffers assembled instructions in a small FIFO with valid/ready handshake toward decode.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, >=2)
ADDR_W, 64, instruction byte-address width

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  reset, asynchronous, active-low
i_flush  input  1  synchronous flush (branch redirect / interrupt)
i_fetch_valid  input  1  fetch word present
o_fetch_ready  output  1  stage accepts fetch word this cycle
i_fetch_word  input  [0:31]  instruction word, bit 0 = MSB
i_fetch_addr  input  [0:ADDR_W-1]  byte address of i_fetch_word
o_valid  output  1  assembled instruction at FIFO head
i_ready  input  1  decode consumes head this cycle
o_instr  output  [0:63]  [0:31] prefix or plain word; [32:63] suffix or zero
o_addr  output  [0:ADDR_W-1]  address of first word of instruction
o_prefixed  output  1  o_instr is a prefixed instruction
o_align_err  output  1  prefix at byte offset 60 of a 64-byte block
o_count  output  [$clog2(DEPTH):0]  FIFO occupancy

Behaviour:
- Reset (i_rst=0, async): FIFO empty, count 0, state IDLE, prefix holding reg cleared. o_valid=0, o_instr=0, o_addr=0, o_prefixed=0, o_align_err=0, o_count=0. o_fetch_ready=1 once i_rst=1.
- Fetch handshake: word accepted when i_fetch_valid & o_fetch_ready.
- o_fetch_ready = !i_flush & (state != HALT) & (count < DEPTH). Combinational from registered state only; no i_ready path.
- Full FIFO never accepts a word, even when a pop occurs the same cycle.
- Prefix detect: i_fetch_word[0:5] == 6'b000001.
- States:
  - IDLE + non-prefix word: push {word, 32'h0}, addr, prefixed=0, err=0; stay IDLE.
  - IDLE + prefix word with addr[ADDR_W-6:ADDR_W-1] != 6'b111100: store word and addr in holding reg; go PREFIX; no push.
  - IDLE + prefix word with addr[ADDR_W-6:ADDR_W-1] == 6'b111100: push {word, 32'h0}, prefixed=1, err=1; go HALT.
  - PREFIX + any word: push {held prefix, word}, held addr, prefixed=1, err=0; go IDLE.
    - The suffix is taken as-is, even if its opcode is 1; suffix content is not checked.
    - Fetch guarantees the suffix address is held addr + 4.
  - HALT: o_fetch_ready=0; the FIFO still drains to decode; leave HALT only on i_flush.
- FIFO:
  - Pop when o_valid & i_ready.
  - Push and pop in the same cycle are both allowed when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: a word accepted in cycle N (plain, or the suffix) appears at the head with o_valid=1 in cycle N+1 if the FIFO was empty. A prefix alone produces no output.
- Outputs o_instr/o_addr/o_prefixed/o_align_err show the head entry; all zero when o_valid=0.
- o_count: registered occupancy, 0..DEPTH.
- Flush (highest priority, synchronous):
  - Empties the FIFO, discards any held prefix, state -> IDLE.
  - Any fetch word or pop presented that cycle is ignored.
  - o_valid=0 the next cycle.
- Reset mid-operation: everything returns to reset values immediately; a partially assembled prefix is lost.

Test Plan:
- Plain stream: words 0x38600005@0x100, 0x48000010@0x104, i_ready=1 -> o_instr=0x38600005_00000000 (addr 0x100) then 0x48000010_00000000 (addr 0x104), one cycle after each accept, o_prefixed=0.
- Prefixed pair: 0x04000000@0x200 then 0x38600005@0x204 -> single entry o_instr=0x04000000_38600005, o_addr=0x200, o_prefixed=1, o_align_err=0; nothing output after the prefix alone.
- Boundary: prefix 0x04000000@0x23C -> entry o_prefixed=1, o_align_err=1, o_instr=0x04000000_00000000; o_fetch_ready=0 thereafter; i_flush -> ready=1, count=0.
- Backpressure: i_ready=0, push 4 plain words -> o_count=4, o_fetch_ready=0. Assert i_ready with fetch valid -> pop only that cycle; accept resumes next cycle. Order preserved across pointer wrap (push 8 total).
- Flush mid-pair: prefix accepted, then i_flush with valid suffix present -> suffix dropped. Next word 0x38600005 emerges as a plain instruction; FIFO empty after the flush cycle.
- Async reset with 2 entries queued and a prefix held -> o_valid=0 and o_count=0 immediately. After release, o_fetch_ready=1 and state is IDLE.
